// File: rtl/pc_ras_unit_if.sv
// Request/response bundle between branch resolution and the PC/return-stack unit.
// The master issues the redirect requests; the slave (the PC unit) drives the fetch PC and stack status.
interface pc_ras_unit_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic             pcwrite;
    logic             exc;
    logic             ret;
    logic [WIDTH-1:0] ret_fallback;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic             call;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] pc_plus;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;

    modport master (
        output pcwrite, exc, ret, ret_fallback, branch_taken, branch_target,
               jump, call, jump_target,
        input  out, pc_plus, ras_count, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  pcwrite, exc, ret, ret_fallback, branch_taken, branch_target,
               jump, call, jump_target,
        output out, pc_plus, ras_count, ras_empty, ras_full, ras_underflow
    );
endinterface

// File: rtl/pc_ras_unit.sv
// Fetch program counter with a fixed-priority next-PC select and a circular return-address stack.
// The stack pointer always names the next free slot; a push into a full stack overwrites the oldest entry.
module pc_ras_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    pc_ras_unit_if.slave    pc
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] pc_r;
    logic [PW-1:0]    ptr_r;
    logic [CW-1:0]    count_r;
    logic             underflow_r;
    logic             empty_r;
    logic             full_r;
    logic [WIDTH-1:0] stack_r [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] pc_n_s;
    logic [PW-1:0]    ptr_n_s;
    logic [CW-1:0]    count_n_s;
    logic             underflow_n_s;
    logic             push_s;

    assign pc_plus_s        = pc_r + WIDTH'(INC);
    assign pc.out           = pc_r;
    assign pc.pc_plus       = pc_plus_s;
    assign pc.ras_count     = count_r;
    assign pc.ras_empty     = empty_r;
    assign pc.ras_full      = full_r;
    assign pc.ras_underflow = underflow_r;

    // Next-state select: exc beats the stall, everything else needs pcwrite; losers have no side effects.
    always_comb begin
        pc_n_s        = pc_r;
        ptr_n_s       = ptr_r;
        count_n_s     = count_r;
        underflow_n_s = 1'b0;
        push_s        = 1'b0;
        if (pc.exc) begin
            pc_n_s    = EXC_VECTOR;
            ptr_n_s   = {PW{1'b0}};
            count_n_s = {CW{1'b0}};
        end else if (pc.pcwrite) begin
            if (pc.ret) begin
                if (count_r != {CW{1'b0}}) begin
                    pc_n_s    = stack_r[ptr_r - PW'(1)];
                    ptr_n_s   = ptr_r - PW'(1);
                    count_n_s = count_r - CW'(1);
                end else begin
                    pc_n_s        = pc.ret_fallback;
                    underflow_n_s = 1'b1;
                end
            end else if (pc.branch_taken) begin
                pc_n_s = pc.branch_target;
            end else if (pc.jump) begin
                pc_n_s = pc.jump_target;
                if (pc.call) begin
                    push_s  = 1'b1;
                    ptr_n_s = ptr_r + PW'(1);
                    if (count_r != CW'(RAS_DEPTH)) begin
                        count_n_s = count_r + CW'(1);
                    end else begin
                        count_n_s = count_r;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end else begin
                pc_n_s = pc_plus_s;
            end
        end else begin
            pc_n_s = pc_r;
        end
    end

    // PC, stack pointer, occupancy flags and stack storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= RESET_VECTOR;
            ptr_r       <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            underflow_r <= 1'b0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pc_r        <= pc_n_s;
            ptr_r       <= ptr_n_s;
            count_r     <= count_n_s;
            underflow_r <= underflow_n_s;
            empty_r     <= (count_n_s == {CW{1'b0}});
            full_r      <= (count_n_s == CW'(RAS_DEPTH));
            if (push_s) begin
                stack_r[ptr_r] <= pc_plus_s;
            end
        end
    end
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: a reference model predicts every cycle into a scoreboard queue
// that is drained and checked on the falling edge after each rising edge.
module tb_pc_ras_unit;
    localparam int W = 32;
    localparam int D = 4;
    localparam logic [31:0] EXC = 32'h0000_0180;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        logic        uf;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    exp_t        sb_q[$];
    logic [31:0] m_stack[$];
    logic [31:0] m_pc;

    pc_ras_unit_if #(.WIDTH(W), .RAS_DEPTH(D)) dut_if ();

    pc_ras_unit #(.WIDTH(W), .RAS_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (dut_if.slave)
    );

    always #5 clk = ~clk;

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (dut_if.out === e.pc) else begin
                fails++;
                $error("FAIL %s out: observed %h expected %h", e.tag, dut_if.out, e.pc);
            end
            checks++;
            assert (dut_if.pc_plus === e.pc + 32'd4) else begin
                fails++;
                $error("FAIL %s pc_plus: observed %h expected %h", e.tag, dut_if.pc_plus, e.pc + 32'd4);
            end
            checks++;
            assert (int'(dut_if.ras_count) === e.cnt) else begin
                fails++;
                $error("FAIL %s ras_count: observed %0d expected %0d", e.tag, dut_if.ras_count, e.cnt);
            end
            checks++;
            assert (dut_if.ras_empty === (e.cnt == 0)) else begin
                fails++;
                $error("FAIL %s ras_empty: observed %b expected %b", e.tag, dut_if.ras_empty, (e.cnt == 0));
            end
            checks++;
            assert (dut_if.ras_full === (e.cnt == D)) else begin
                fails++;
                $error("FAIL %s ras_full: observed %b expected %b", e.tag, dut_if.ras_full, (e.cnt == D));
            end
            checks++;
            assert (dut_if.ras_underflow === e.uf) else begin
                fails++;
                $error("FAIL %s ras_underflow: observed %b expected %b", e.tag, dut_if.ras_underflow, e.uf);
            end
        end
    endtask

    task automatic step(input logic pw, input logic e, input logic r, input logic [31:0] fb,
                        input logic bt, input logic [31:0] btg, input logic j, input logic c,
                        input logic [31:0] jt, input string tag);
        exp_t x;
        logic uf;
        dut_if.pcwrite       = pw;
        dut_if.exc           = e;
        dut_if.ret           = r;
        dut_if.ret_fallback  = fb;
        dut_if.branch_taken  = bt;
        dut_if.branch_target = btg;
        dut_if.jump          = j;
        dut_if.call          = c;
        dut_if.jump_target   = jt;
        uf = 1'b0;
        if (e) begin
            m_pc = EXC;
            m_stack.delete();
        end else if (pw) begin
            if (r) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc = fb;
                    uf   = 1'b1;
                end
            end else if (bt) begin
                m_pc = btg;
            end else if (j) begin
                if (c) begin
                    if (m_stack.size() == D) m_stack.delete(0);
                    m_stack.push_back(m_pc + 32'd4);
                end
                m_pc = jt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        x.pc = m_pc; x.cnt = m_stack.size(); x.uf = uf; x.tag = tag;
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic plan(input logic [31:0] exp, input string tag);
        checks++;
        assert (dut_if.out === exp) else begin
            fails++;
            $error("FAIL %s plan_pc: observed %h expected %h", tag, dut_if.out, exp);
        end
    endtask

    initial begin
        exp_t x;
        clk = 1'b0; reset = 1'b0; checks = 0; fails = 0;
        m_pc = 32'h0;
        dut_if.pcwrite = 1'b0; dut_if.exc = 1'b0; dut_if.ret = 1'b0; dut_if.ret_fallback = 32'h0;
        dut_if.branch_taken = 1'b0; dut_if.branch_target = 32'h0; dut_if.jump = 1'b0;
        dut_if.call = 1'b0; dut_if.jump_target = 32'h0;
        repeat (2) @(negedge clk);
        x.pc = 32'h0; x.cnt = 0; x.uf = 1'b0; x.tag = "reset";
        sb_q.push_back(x);
        drain();
        reset = 1'b1;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, "seq");
        plan(32'hC, "seq3");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, "call_no_jump");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "stall1");
        step(0, 0, 1, 32'h999, 1, 32'h888, 1, 1, 32'h777, "stall_reqs");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "exc_stalled");
        plan(32'h180, "exc");

        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h20, "jump20");
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h100, "call100");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "seq104");
        step(1, 0, 1, 32'h300, 0, 0, 0, 0, 0, "ret24");
        plan(32'h24, "ret24");

        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h40, "jump40");
        step(1, 0, 1, 32'h300, 1, 32'h80, 1, 1, 32'h200, "ret_wins_empty");
        plan(32'h300, "underflow_fb");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "uf_clears");

        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, "jump0");
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 0, 1, 1, 32'h1000 * i, "call_chain");
        step(1, 0, 1, 32'h300, 0, 0, 0, 0, 0, "ret1");
        plan(32'h4004, "ret_newest");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h300, 0, 0, 0, 0, 0, "ret_more");
        plan(32'h1004, "ret_fourth");
        step(1, 0, 1, 32'h300, 0, 0, 0, 0, 0, "ret_underflow");
        step(1, 1, 1, 32'h300, 0, 0, 0, 0, 0, "exc_over_ret");

        step(1, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, "jump_top");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "wrap");
        plan(32'h0, "wrap0");
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h500, "call_pre_reset");

        dut_if.jump = 1'b1; dut_if.call = 1'b1; dut_if.jump_target = 32'h600;
        #2 reset = 1'b0;
        m_pc = 32'h0;
        m_stack.delete();
        x.pc = 32'h0; x.cnt = 0; x.uf = 1'b0; x.tag = "async_reset";
        sb_q.push_back(x);
        #1 drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
